mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 83 ++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with multi-cycle data memory, stall generation and MEM/WB register.
module mem_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_MemReadOut,
  input  logic        EX_MEM_MemWriteOut,
  input  logic        EX_MEM_MemtoRegOut,
  input  logic        EX_MEM_RegWrite,
  input  logic        EX_MEM_Branch,
  input  logic [7:0]  EX_MEM_BranchTarget,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic [4:0]  EX_MEM_WriteReg,
  output logic        MEM_Stall,
  output logic        MEM_PCSrc,
  output logic [7:0]  MEM_BranchTarget,
  output logic        MEM_WB_RegWrite,
  output logic        MEM_WB_MemtoReg,
  output logic [31:0] MEM_WB_ReadData,
  output logic [31:0] MEM_WB_ALUResult,
  output logic [4:0]  MEM_WB_WriteReg
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] LAST  = 4'(MEM_LATENCY - 1);
  localparam bit         MULTI = MEM_LATENCY > 1;
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]   addr;
  logic                mem_op, done;
  assign addr   = EX_MEM_ALUResult[ADDR_W-1:0];
  assign mem_op = EX_MEM_MemReadOut | EX_MEM_MemWriteOut;
  assign done   = ~MEM_Stall;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    MEM_Stall = 1'b0;
    if (state_q == IDLE) begin
      if (mem_op && MULTI) begin
        state_d   = BUSY;
        cnt_d     = 4'd1;
        MEM_Stall = rst;
      end
    end else if (cnt_q < LAST) begin
      cnt_d     = cnt_q + 4'd1;
      MEM_Stall = rst;
    end else begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end
  end
  // Memory is not reset; a low rst at the edge suppresses an in-flight store.
  always_ff @(posedge clk)
    if (rst && done && EX_MEM_MemWriteOut) mem[addr] <= EX_MEM_WriteData;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      cnt_q            <= 4'd0;
      MEM_PCSrc        <= 1'b0;
      MEM_BranchTarget <= 8'd0;
      MEM_WB_RegWrite  <= 1'b0;
      MEM_WB_MemtoReg  <= 1'b0;
      MEM_WB_ReadData  <= 32'd0;
      MEM_WB_ALUResult <= 32'd0;
      MEM_WB_WriteReg  <= 5'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      MEM_PCSrc        <= done & EX_MEM_Branch;
      MEM_BranchTarget <= (done && EX_MEM_Branch) ? EX_MEM_BranchTarget : 8'd0;
      MEM_WB_RegWrite  <= done & EX_MEM_RegWrite;
      MEM_WB_MemtoReg  <= done & EX_MEM_MemtoRegOut;
      if (done) begin
        MEM_WB_ReadData  <= EX_MEM_MemReadOut ? mem[addr] : 32'd0;
        MEM_WB_ALUResult <= EX_MEM_ALUResult;
        MEM_WB_WriteReg  <= EX_MEM_WriteReg;
      end
    end
  end
endmodule
